// File: rtl/control_fsm_pkg.sv
// Shared types, MIPS opcode/function codes and the instruction-class decoder for control_fsm.
// Purely declarative: no state, no latency.
package control_fsm_pkg;

    typedef logic [5:0] opcode_t;
    typedef logic [5:0] func_t;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        FETCH       = 3'd1,
        EXEC1       = 3'd2,
        MULDIV_WAIT = 3'd3,
        EXEC2       = 3'd4,
        HALT        = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        REGFILE_ADDR_SEL_RT = 2'd0,
        REGFILE_ADDR_SEL_RD = 2'd1,
        REGFILE_ADDR_SEL_RA = 2'd2
    } regfile_addr_sel_t;

    typedef enum logic [1:0] {
        SIZE_WORD = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_BYTE = 2'd2
    } mem_size_t;

    localparam opcode_t OP_SPECIAL = 6'h00;
    localparam opcode_t OP_REGIMM  = 6'h01;
    localparam opcode_t OP_J       = 6'h02;
    localparam opcode_t OP_JAL     = 6'h03;
    localparam opcode_t OP_BEQ     = 6'h04;
    localparam opcode_t OP_BNE     = 6'h05;
    localparam opcode_t OP_BLEZ    = 6'h06;
    localparam opcode_t OP_BGTZ    = 6'h07;
    localparam opcode_t OP_ADDIU   = 6'h09;
    localparam opcode_t OP_SLTI    = 6'h0a;
    localparam opcode_t OP_SLTIU   = 6'h0b;
    localparam opcode_t OP_ANDI    = 6'h0c;
    localparam opcode_t OP_ORI     = 6'h0d;
    localparam opcode_t OP_XORI    = 6'h0e;
    localparam opcode_t OP_LUI     = 6'h0f;
    localparam opcode_t OP_LB      = 6'h20;
    localparam opcode_t OP_LH      = 6'h21;
    localparam opcode_t OP_LW      = 6'h23;
    localparam opcode_t OP_LBU     = 6'h24;
    localparam opcode_t OP_LHU     = 6'h25;
    localparam opcode_t OP_SB      = 6'h28;
    localparam opcode_t OP_SH      = 6'h29;
    localparam opcode_t OP_SW      = 6'h2b;

    localparam func_t FN_SLL   = 6'h00;
    localparam func_t FN_SRL   = 6'h02;
    localparam func_t FN_SRA   = 6'h03;
    localparam func_t FN_SLLV  = 6'h04;
    localparam func_t FN_SRLV  = 6'h06;
    localparam func_t FN_SRAV  = 6'h07;
    localparam func_t FN_JR    = 6'h08;
    localparam func_t FN_JALR  = 6'h09;
    localparam func_t FN_MFHI  = 6'h10;
    localparam func_t FN_MTHI  = 6'h11;
    localparam func_t FN_MFLO  = 6'h12;
    localparam func_t FN_MTLO  = 6'h13;
    localparam func_t FN_MULT  = 6'h18;
    localparam func_t FN_MULTU = 6'h19;
    localparam func_t FN_DIV   = 6'h1a;
    localparam func_t FN_DIVU  = 6'h1b;
    localparam func_t FN_ADD   = 6'h20;
    localparam func_t FN_ADDU  = 6'h21;
    localparam func_t FN_SUB   = 6'h22;
    localparam func_t FN_SUBU  = 6'h23;
    localparam func_t FN_AND   = 6'h24;
    localparam func_t FN_OR    = 6'h25;
    localparam func_t FN_XOR   = 6'h26;
    localparam func_t FN_NOR   = 6'h27;
    localparam func_t FN_SLT   = 6'h2a;
    localparam func_t FN_SLTU  = 6'h2b;

    typedef struct packed {
        logic      load;
        logic      store;
        logic      muldiv;
        logic      div;
        mem_size_t size;
        logic      wr_rt;
        logic      wr_rd;
        logic      wr_ra;
    } decode_t;

    // Anything not listed decodes to all-zero, i.e. a NOP through EXEC2.
    function automatic decode_t decode(opcode_t op, func_t fn);
        decode_t d;
        d      = '0;
        d.size = SIZE_WORD;
        case (op)
            OP_SPECIAL: begin
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR,
                    FN_XOR, FN_NOR, FN_SLT, FN_SLTU,
                    FN_MFHI, FN_MFLO, FN_JALR: d.wr_rd = 1'b1;
                    FN_MULT, FN_MULTU:         d.muldiv = 1'b1;
                    FN_DIV, FN_DIVU: begin
                        d.muldiv = 1'b1;
                        d.div    = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                d.load  = 1'b1;
                d.wr_rt = 1'b1;
            end
            OP_LH, OP_LHU: begin
                d.load  = 1'b1;
                d.wr_rt = 1'b1;
                d.size  = SIZE_HALF;
            end
            OP_LB, OP_LBU: begin
                d.load  = 1'b1;
                d.wr_rt = 1'b1;
                d.size  = SIZE_BYTE;
            end
            OP_SW: d.store = 1'b1;
            OP_SH: begin
                d.store = 1'b1;
                d.size  = SIZE_HALF;
            end
            OP_SB: begin
                d.store = 1'b1;
                d.size  = SIZE_BYTE;
            end
            OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI,
            OP_ORI, OP_XORI, OP_LUI: d.wr_rt = 1'b1;
            OP_JAL:                  d.wr_ra = 1'b1;
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Memory-port bundle between control_fsm (master) and the bus/datapath side (slave).
// Names are from the controller's point of view; no storage, no latency.
interface control_fsm_if #(
    parameter int BYTE_LANES = 4
);
    localparam int AW = $clog2(BYTE_LANES);

    logic [AW-1:0]         addr_low_i;
    logic                  waitrequest_i;
    logic                  mem_read_o;
    logic                  mem_write_o;
    logic [BYTE_LANES-1:0] mem_byte_en_o;
    logic                  mem_addr_sel_o;

    modport master (
        input  addr_low_i,
        input  waitrequest_i,
        output mem_read_o,
        output mem_write_o,
        output mem_byte_en_o,
        output mem_addr_sel_o
    );

    modport slave (
        output addr_low_i,
        output waitrequest_i,
        input  mem_read_o,
        input  mem_write_o,
        input  mem_byte_en_o,
        input  mem_addr_sel_o
    );
endinterface

// File: rtl/control_fsm_byte_lane_gen.sv
// Little-endian byte-enable and alignment check from access size and low address bits.
// Combinational, zero latency, no backpressure.
module control_fsm_byte_lane_gen
    import control_fsm_pkg::*;
#(
    parameter  int BYTE_LANES = 4,
    localparam int AW         = $clog2(BYTE_LANES)
) (
    input  mem_size_t             size_i,
    input  logic [AW-1:0]         addr_low_i,
    output logic [BYTE_LANES-1:0] byte_en_o,
    output logic                  misaligned_o
);
    localparam logic [BYTE_LANES-1:0] BYTE_MASK = BYTE_LANES'(1);
    localparam logic [BYTE_LANES-1:0] HALF_MASK = BYTE_LANES'(3);

    always_comb begin
        byte_en_o    = '0;
        misaligned_o = 1'b0;
        case (size_i)
            SIZE_WORD: begin
                if (addr_low_i == '0) byte_en_o = '1;
                else                  misaligned_o = 1'b1;
            end
            SIZE_HALF: begin
                if (!addr_low_i[0]) byte_en_o = HALF_MASK << addr_low_i;
                else                misaligned_o = 1'b1;
            end
            SIZE_BYTE: byte_en_o = BYTE_MASK << addr_low_i;
            default:   misaligned_o = 1'b1;
        endcase
    end
endmodule

// File: rtl/control_fsm.sv
// Multicycle MIPS controller: state + mul/div counter are the only flops, all outputs decode combinationally.
// Min latency 3 cycles (mul/div 3+LATENCY); each waitrequest cycle stalls FETCH/load/store by one cycle.
module control_fsm
    import control_fsm_pkg::*;
#(
    parameter int BYTE_LANES   = 4,
    parameter int MULT_LATENCY = 1,
    parameter int DIV_LATENCY  = 32
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  opcode_t           opcode_i,
    input  func_t             function_i,
    input  logic              pc_halt_i,
    control_fsm_if.master     mem_if,
    output state_t            state_o,
    output logic              active_o,
    output logic              pc_write_en_o,
    output logic              ir_write_en_o,
    output logic              mdr_write_en_o,
    output logic              src_b_sel_o,
    output logic              regfile_write_en_o,
    output regfile_addr_sel_t regfile_addr_3_sel_o,
    output logic              muldiv_start_o,
    output logic              hi_lo_write_en_o,
    output logic              align_err_o
);
    localparam int MAX_LAT = (DIV_LATENCY > MULT_LATENCY) ? DIV_LATENCY : MULT_LATENCY;
    localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    decode_t               dec;
    logic [BYTE_LANES-1:0] lane_be;
    logic                  lane_mis;

    logic                  mem_read, mem_write, addr_sel;
    logic [BYTE_LANES-1:0] byte_en;

    assign dec = decode(opcode_i, function_i);

    control_fsm_byte_lane_gen #(.BYTE_LANES(BYTE_LANES)) u_lanes (
        .size_i       (dec.size),
        .addr_low_i   (mem_if.addr_low_i),
        .byte_en_o    (lane_be),
        .misaligned_o (lane_mis)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        cnt_d                = cnt_q;
        active_o             = 1'b0;
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        mdr_write_en_o       = 1'b0;
        mem_read             = 1'b0;
        mem_write            = 1'b0;
        byte_en              = '0;
        addr_sel             = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RT;
        muldiv_start_o       = 1'b0;
        hi_lo_write_en_o     = 1'b0;
        align_err_o          = 1'b0;
        case (state_q)
            IDLE: state_d = FETCH;
            FETCH: begin
                active_o = 1'b1;
                if (pc_halt_i) begin
                    state_d = HALT;
                end else begin
                    mem_read = 1'b1;
                    byte_en  = '1;
                    if (!mem_if.waitrequest_i) begin
                        ir_write_en_o = 1'b1;
                        state_d       = EXEC1;
                    end
                end
            end
            EXEC1: begin
                active_o = 1'b1;
                if (dec.load) begin
                    addr_sel    = 1'b1;
                    src_b_sel_o = 1'b1;
                    // A misaligned load never touches the bus, so waitrequest is irrelevant.
                    if (lane_mis) begin
                        align_err_o = 1'b1;
                        state_d     = EXEC2;
                    end else begin
                        mem_read = 1'b1;
                        byte_en  = lane_be;
                        if (!mem_if.waitrequest_i) begin
                            mdr_write_en_o = 1'b1;
                            state_d        = EXEC2;
                        end
                    end
                end else if (dec.muldiv) begin
                    muldiv_start_o = 1'b1;
                    cnt_d   = dec.div ? CW'(DIV_LATENCY - 1) : CW'(MULT_LATENCY - 1);
                    state_d = MULDIV_WAIT;
                end else begin
                    state_d = EXEC2;
                end
            end
            MULDIV_WAIT: begin
                active_o = 1'b1;
                if (cnt_q == '0) begin
                    hi_lo_write_en_o = 1'b1;
                    state_d          = EXEC2;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            EXEC2: begin
                active_o = 1'b1;
                if (dec.store) begin
                    addr_sel    = 1'b1;
                    src_b_sel_o = 1'b1;
                    if (lane_mis) begin
                        align_err_o   = 1'b1;
                        pc_write_en_o = 1'b1;
                        state_d       = FETCH;
                    end else begin
                        mem_write = 1'b1;
                        byte_en   = lane_be;
                        if (!mem_if.waitrequest_i) begin
                            pc_write_en_o = 1'b1;
                            state_d       = FETCH;
                        end
                    end
                end else begin
                    pc_write_en_o = 1'b1;
                    state_d       = FETCH;
                    if (dec.wr_rt) begin
                        src_b_sel_o        = 1'b1;
                        regfile_write_en_o = !(dec.load && lane_mis);
                    end else if (dec.wr_rd) begin
                        regfile_write_en_o   = 1'b1;
                        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RD;
                    end else if (dec.wr_ra) begin
                        regfile_write_en_o   = 1'b1;
                        regfile_addr_3_sel_o = REGFILE_ADDR_SEL_RA;
                    end
                end
            end
            HALT: state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    assign state_o               = state_q;
    assign mem_if.mem_read_o     = mem_read;
    assign mem_if.mem_write_o    = mem_write;
    assign mem_if.mem_byte_en_o  = byte_en;
    assign mem_if.mem_addr_sel_o = addr_sel;
endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: stimulus queues hand-computed per-cycle outputs, a monitor compares them.
module tb_control_fsm;
    import control_fsm_pkg::*;

    typedef struct packed {
        state_t            st;
        logic              act, pcw, irw, mdrw, rd, wr;
        logic [3:0]        be;
        logic              asel, srcb, rfw;
        regfile_addr_sel_t rsel;
        logic              mds, hlw, aerr;
    } obs_t;

    logic              clk = 1'b0;
    logic              rst_n;
    opcode_t           op;
    func_t             fn;
    logic              ph;
    state_t            state;
    logic              active, pc_we, ir_we, mdr_we, src_b, rf_we, md_start, hl_we, aerr;
    regfile_addr_sel_t rf_sel;

    obs_t  exp_q[$];
    string tag_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    control_fsm_if #(.BYTE_LANES(4)) mif ();

    control_fsm #(.BYTE_LANES(4), .MULT_LATENCY(1), .DIV_LATENCY(32)) dut (
        .clk_i                (clk),
        .rst_n_i              (rst_n),
        .opcode_i             (op),
        .function_i           (fn),
        .pc_halt_i            (ph),
        .mem_if               (mif.master),
        .state_o              (state),
        .active_o             (active),
        .pc_write_en_o        (pc_we),
        .ir_write_en_o        (ir_we),
        .mdr_write_en_o       (mdr_we),
        .src_b_sel_o          (src_b),
        .regfile_write_en_o   (rf_we),
        .regfile_addr_3_sel_o (rf_sel),
        .muldiv_start_o       (md_start),
        .hi_lo_write_en_o     (hl_we),
        .align_err_o          (aerr)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.st = state;       o.act = active;   o.pcw = pc_we;   o.irw = ir_we;
        o.mdrw = mdr_we;    o.rd = mif.mem_read_o;  o.wr = mif.mem_write_o;
        o.be = mif.mem_byte_en_o;  o.asel = mif.mem_addr_sel_o;  o.srcb = src_b;
        o.rfw = rf_we;      o.rsel = rf_sel;  o.mds = md_start; o.hlw = hl_we; o.aerr = aerr;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("st=%0d act=%b pcw=%b irw=%b mdrw=%b rd=%b wr=%b be=%b asel=%b srcb=%b rfw=%b rsel=%0d mds=%b hlw=%b aerr=%b",
                         o.st, o.act, o.pcw, o.irw, o.mdrw, o.rd, o.wr, o.be, o.asel, o.srcb,
                         o.rfw, o.rsel, o.mds, o.hlw, o.aerr);
    endfunction

    // Expected-vector builders; every argument is a hand-computed value.
    function automatic obs_t blank(state_t s, logic act);
        obs_t e;
        e = '0;
        e.st = s;
        e.act = act;
        return e;
    endfunction
    function automatic obs_t f_fetch(logic irw);
        obs_t e = blank(FETCH, 1'b1);
        e.rd = 1'b1; e.be = 4'hf; e.irw = irw;
        return e;
    endfunction
    function automatic obs_t f_ld(logic rd, logic [3:0] be, logic mdrw, logic ae);
        obs_t e = blank(EXEC1, 1'b1);
        e.asel = 1'b1; e.srcb = 1'b1; e.rd = rd; e.be = be; e.mdrw = mdrw; e.aerr = ae;
        return e;
    endfunction
    function automatic obs_t f_st(logic wr, logic [3:0] be, logic pcw, logic ae);
        obs_t e = blank(EXEC2, 1'b1);
        e.asel = 1'b1; e.srcb = 1'b1; e.wr = wr; e.be = be; e.pcw = pcw; e.aerr = ae;
        return e;
    endfunction
    function automatic obs_t f_md_start();
        obs_t e = blank(EXEC1, 1'b1);
        e.mds = 1'b1;
        return e;
    endfunction
    function automatic obs_t f_wait(logic hlw);
        obs_t e = blank(MULDIV_WAIT, 1'b1);
        e.hlw = hlw;
        return e;
    endfunction
    function automatic obs_t f_e2(logic rfw, regfile_addr_sel_t sel, logic srcb);
        obs_t e = blank(EXEC2, 1'b1);
        e.pcw = 1'b1; e.rfw = rfw; e.rsel = sel; e.srcb = srcb;
        return e;
    endfunction

    task automatic cyc(input obs_t e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic expect_now(input obs_t e, input string tag);
        obs_t a;
        a = sample();
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %s | want %s", tag, fmt(a), fmt(e));
        end
    endtask

    task automatic set_instr(input opcode_t o, input func_t f, input logic [1:0] a);
        op = o;
        fn = f;
        mif.addr_low_i = a;
    endtask

    // Plain three-cycle instruction: FETCH, EXEC1, EXEC2.
    task automatic simple(input opcode_t o, input func_t f, input obs_t e2, input string tag);
        set_instr(o, f, 2'd0);
        cyc(f_fetch(1'b1), {tag, ".fetch"});
        cyc(blank(EXEC1, 1'b1), {tag, ".e1"});
        cyc(e2, {tag, ".e2"});
    endtask

    initial begin : monitor
        obs_t  e, a;
        string t;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                a = sample();
                n_tests++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s | want %s", t, fmt(a), fmt(e));
                end
            end
        end
    end

    initial begin : stim
        logic [3:0] sb_be [4];
        sb_be[0] = 4'b0001; sb_be[1] = 4'b0010; sb_be[2] = 4'b0100; sb_be[3] = 4'b1000;

        rst_n = 1'b0; ph = 1'b0; mif.waitrequest_i = 1'b0;
        set_instr(OP_ADDIU, FN_SLL, 2'd0);
        @(posedge clk); #1;
        expect_now(blank(IDLE, 1'b0), "reset_state");
        cyc(blank(IDLE, 1'b0), "reset0");
        cyc(blank(IDLE, 1'b0), "reset1");
        rst_n = 1'b1;
        cyc(blank(IDLE, 1'b0), "idle");

        simple(OP_ADDIU, FN_SLL, f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "addiu");

        // LW: 2 FETCH waits and 3 EXEC1 waits -> 8 cycles, one mdr write.
        set_instr(OP_LW, FN_SLL, 2'd0);
        mif.waitrequest_i = 1'b1;
        for (int i = 0; i < 2; i++) cyc(f_fetch(1'b0), "lw.fetch_wait");
        mif.waitrequest_i = 1'b0;
        cyc(f_fetch(1'b1), "lw.fetch");
        mif.waitrequest_i = 1'b1;
        for (int i = 0; i < 3; i++) cyc(f_ld(1'b1, 4'hf, 1'b0, 1'b0), "lw.e1_wait");
        mif.waitrequest_i = 1'b0;
        cyc(f_ld(1'b1, 4'hf, 1'b1, 1'b0), "lw.e1");
        cyc(f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "lw.e2");

        simple(OP_SPECIAL, FN_ADDU, f_e2(1'b1, REGFILE_ADDR_SEL_RD, 1'b0), "addu");

        for (int i = 0; i < 4; i++) begin
            set_instr(OP_SB, FN_SLL, 2'(i));
            cyc(f_fetch(1'b1), "sb.fetch");
            cyc(blank(EXEC1, 1'b1), "sb.e1");
            cyc(f_st(1'b1, sb_be[i], 1'b1, 1'b0), $sformatf("sb.a%0d", i));
        end

        set_instr(OP_SH, FN_SLL, 2'd2);
        cyc(f_fetch(1'b1), "sh2.fetch");
        cyc(blank(EXEC1, 1'b1), "sh2.e1");
        cyc(f_st(1'b1, 4'b1100, 1'b1, 1'b0), "sh.a2");

        set_instr(OP_SH, FN_SLL, 2'd1);
        cyc(f_fetch(1'b1), "sh1.fetch");
        cyc(blank(EXEC1, 1'b1), "sh1.e1");
        cyc(f_st(1'b0, 4'b0000, 1'b1, 1'b1), "sh.a1_misaligned");

        // SW with one write stall.
        set_instr(OP_SW, FN_SLL, 2'd0);
        cyc(f_fetch(1'b1), "sw.fetch");
        cyc(blank(EXEC1, 1'b1), "sw.e1");
        mif.waitrequest_i = 1'b1;
        cyc(f_st(1'b1, 4'hf, 1'b0, 1'b0), "sw.e2_wait");
        mif.waitrequest_i = 1'b0;
        cyc(f_st(1'b1, 4'hf, 1'b1, 1'b0), "sw.e2");

        set_instr(OP_SW, FN_SLL, 2'd2);
        cyc(f_fetch(1'b1), "sw2.fetch");
        cyc(blank(EXEC1, 1'b1), "sw2.e1");
        cyc(f_st(1'b0, 4'b0000, 1'b1, 1'b1), "sw.a2_misaligned");

        set_instr(OP_LBU, FN_SLL, 2'd3);
        cyc(f_fetch(1'b1), "lbu.fetch");
        cyc(f_ld(1'b1, 4'b1000, 1'b1, 1'b0), "lbu.a3");
        cyc(f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "lbu.e2");

        set_instr(OP_LHU, FN_SLL, 2'd2);
        cyc(f_fetch(1'b1), "lhu.fetch");
        cyc(f_ld(1'b1, 4'b1100, 1'b1, 1'b0), "lhu.a2");
        cyc(f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "lhu.e2");

        // Misaligned LH: waitrequest held high to show the bus is not used.
        set_instr(OP_LH, FN_SLL, 2'd1);
        cyc(f_fetch(1'b1), "lh1.fetch");
        mif.waitrequest_i = 1'b1;
        cyc(f_ld(1'b0, 4'b0000, 1'b0, 1'b1), "lh.a1_misaligned");
        mif.waitrequest_i = 1'b0;
        cyc(f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b1), "lh1.e2_nowrite");

        set_instr(OP_SPECIAL, FN_MULT, 2'd0);
        cyc(f_fetch(1'b1), "mult.fetch");
        cyc(f_md_start(), "mult.start");
        expect_now(f_wait(1'b1), "mult.wait_expired");
        cyc(f_wait(1'b1), "mult.wait_last");
        cyc(f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "mult.e2");

        // DIV: FETCH at 0, start at 1, 32 wait cycles, EXEC2 at 34, next FETCH at 35.
        set_instr(OP_SPECIAL, FN_DIV, 2'd0);
        cyc(f_fetch(1'b1), "div.fetch");
        cyc(f_md_start(), "div.start");
        for (int i = 0; i < 31; i++) cyc(f_wait(1'b0), "div.wait");
        expect_now(f_wait(1'b1), "div.wait_expired");
        cyc(f_wait(1'b1), "div.wait_last");
        cyc(f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "div.e2");

        simple(OP_JAL, FN_SLL, f_e2(1'b1, REGFILE_ADDR_SEL_RA, 1'b0), "jal");
        simple(OP_SPECIAL, FN_JALR, f_e2(1'b1, REGFILE_ADDR_SEL_RD, 1'b0), "jalr");
        simple(OP_SPECIAL, FN_MFHI, f_e2(1'b1, REGFILE_ADDR_SEL_RD, 1'b0), "mfhi");
        simple(OP_SPECIAL, FN_MTLO, f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "mtlo");
        simple(OP_BEQ, FN_SLL, f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "beq");
        simple(OP_ORI, FN_SLL, f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "ori");
        simple(6'h3f, FN_SLL, f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "undef_op");
        simple(OP_SPECIAL, 6'h3f, f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "undef_fn");

        // Reset in the middle of a DIV wait.
        set_instr(OP_SPECIAL, FN_DIVU, 2'd0);
        cyc(f_fetch(1'b1), "divu.fetch");
        cyc(f_md_start(), "divu.start");
        for (int i = 0; i < 5; i++) cyc(f_wait(1'b0), "divu.wait");
        rst_n = 1'b0;
        #1;
        expect_now(blank(IDLE, 1'b0), "divu.reset_immediate");
        cyc(blank(IDLE, 1'b0), "divu.reset_same_cycle");
        rst_n = 1'b1;
        cyc(blank(IDLE, 1'b0), "divu.idle_after");
        simple(OP_ADDIU, FN_SLL, f_e2(1'b1, REGFILE_ADDR_SEL_RT, 1'b1), "restart");

        // Reset during a stalled FETCH drops the read strobe immediately.
        mif.waitrequest_i = 1'b1;
        cyc(f_fetch(1'b0), "stall.fetch");
        rst_n = 1'b0;
        cyc(blank(IDLE, 1'b0), "stall.reset");
        rst_n = 1'b1;
        mif.waitrequest_i = 1'b0;
        cyc(blank(IDLE, 1'b0), "stall.idle");

        // MULT after reset proves the counter restarts cleanly.
        set_instr(OP_SPECIAL, FN_MULTU, 2'd0);
        cyc(f_fetch(1'b1), "multu.fetch");
        cyc(f_md_start(), "multu.start");
        cyc(f_wait(1'b1), "multu.wait_last");
        cyc(f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "multu.e2");

        simple(OP_SPECIAL, FN_JR, f_e2(1'b0, REGFILE_ADDR_SEL_RT, 1'b0), "jr");
        ph = 1'b1;
        cyc(blank(FETCH, 1'b1), "halt.fetch_no_read");
        for (int i = 0; i < 100; i++) begin
            mif.waitrequest_i = i[0];
            ph = i[1];
            cyc(blank(HALT, 1'b0), "halt.sticky");
        end

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
